axi_read_sched: RTL and testbench

AXI_READ_SCHED -- requirements
Module: axi_read_sched

---
 rtl/axi_sched_pkg.sv | 9 +
 rtl/rr_pick2.sv | 10 +
 rtl/axi_read_sched.sv | 91 +++++++++
 tb/tb_axi_read_sched.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/axi_sched_pkg.sv
// axi_sched_pkg: shared states, grant encodings and default sizing for the AXI read scheduler.
package axi_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNTW_DEF = 8;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; a lone requester wins, a tie goes to the pointer.
module rr_pick2
  import axi_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  assign gnt = &req ? (ptr ? GNT_M1 : GNT_M0) : req;
endmodule

// File: rtl/axi_read_sched.sv
// axi_read_sched: grants one AXI read burst at a time to M0/M1 with round-robin
// arbitration and an idle-beat watchdog that abandons stalled bursts.
module axi_read_sched
  import axi_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arvalid_m0,
  input  logic            arvalid_m1,
  input  logic            arready_s,
  input  logic            rvalid_s,
  input  logic            rready_m,
  input  logic            rlast_s,
  output logic [1:0]      grant,
  output logic            ar_en,
  output logic            ar_fire,
  output logic            busy,
  output logic [CNTW-1:0] beat_cnt,
  output logic            timeout
);
  state_t            r_state;
  logic              r_ptr;
  logic [CNTW-1:0]   r_wd;
  logic [1:0]        w_arv;
  logic [1:0]        w_pick;
  logic              w_gvalid;
  logic              w_beat;
  logic              w_expire;
  assign w_arv    = {arvalid_m1, arvalid_m0};
  assign w_gvalid = |(grant & w_arv);
  assign ar_fire  = (r_state == S_ADDR) && w_gvalid && arready_s;
  assign w_beat   = (r_state == S_DATA) && rvalid_s && rready_m;
  assign w_expire = (r_state == S_DATA) && !w_beat && (r_wd == CNTW'(TIMEOUT - 1));
  rr_pick2 u_pick (.req(w_arv), .ptr(r_ptr), .gnt(w_pick));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'b0;
      r_wd     <= '0;
      grant    <= GNT_NONE;
      ar_en    <= 1'b0;
      busy     <= 1'b0;
      beat_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        S_IDLE: if (|w_arv) begin
          r_state <= S_ADDR;
          grant   <= w_pick;
          ar_en   <= 1'b1;
          busy    <= 1'b1;
        end
        S_ADDR: if (ar_fire) begin
          r_state  <= S_DATA;
          ar_en    <= 1'b0;
          beat_cnt <= '0;
          r_wd     <= '0;
        end else if (!w_gvalid) begin
          r_state <= S_IDLE;
          grant   <= GNT_NONE;
          ar_en   <= 1'b0;
          busy    <= 1'b0;
        end
        S_DATA: if (w_beat) begin
          beat_cnt <= &beat_cnt ? beat_cnt : beat_cnt + 1'b1;
          r_wd     <= '0;
          if (rlast_s) begin
            r_state <= S_IDLE;
            grant   <= GNT_NONE;
            busy    <= 1'b0;
            r_ptr   <= grant[0];
          end
        end else if (w_expire) begin
          r_state <= S_IDLE;
          grant   <= GNT_NONE;
          busy    <= 1'b0;
          r_ptr   <= grant[0];
          r_wd    <= '0;
          timeout <= 1'b1;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_read_sched.sv
// tb_axi_read_sched: directed scenarios plus randomized traffic checked against a burst-level model.
module tb_axi_read_sched;
  localparam int TO = 8;
  localparam int CW = 3;
  localparam int BMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic arvalid_m0 = 0, arvalid_m1 = 0, arready_s = 0, rvalid_s = 0, rready_m = 0, rlast_s = 0;
  logic [1:0] grant;
  logic ar_en, ar_fire, busy, timeout;
  logic [CW-1:0] beat_cnt;
  int vecs = 0, miss = 0;
  int m_ph = 0, m_own = 0, m_ptr = 0, m_beats = 0, m_idle = 0;
  bit m_to = 0;
  axi_read_sched #(.TIMEOUT(TO), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .arvalid_m0(arvalid_m0), .arvalid_m1(arvalid_m1),
    .arready_s(arready_s), .rvalid_s(rvalid_s), .rready_m(rready_m), .rlast_s(rlast_s),
    .grant(grant), .ar_en(ar_en), .ar_fire(ar_fire), .busy(busy),
    .beat_cnt(beat_cnt), .timeout(timeout)
  );
  always #5 clk = ~clk;
  // Burst-level model: phase 0 idle, 1 address, 2 data; owner is the master index.
  always @(posedge clk or posedge rst) begin
    logic [1:0] arv;
    arv = {arvalid_m1, arvalid_m0};
    if (rst) begin
      m_ph = 0; m_own = 0; m_ptr = 0; m_beats = 0; m_idle = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_ph == 0) begin
        if (arv != 0) begin
          m_own = (arv == 2'b11) ? m_ptr : (arv[1] ? 1 : 0);
          m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (arv[m_own] && arready_s) begin
          m_ph = 2; m_beats = 0; m_idle = 0;
        end else if (!arv[m_own]) m_ph = 0;
      end else begin
        if (rvalid_s && rready_m) begin
          if (m_beats < BMAX) m_beats++;
          m_idle = 0;
          if (rlast_s) begin m_ph = 0; m_ptr = 1 - m_own; end
        end else if (m_idle == TO - 1) begin
          m_ph = 0; m_ptr = 1 - m_own; m_idle = 0; m_to = 1;
        end else m_idle++;
      end
    end
  end
  always @(negedge clk) begin
    logic [1:0] arv, eg;
    logic ef;
    arv = {arvalid_m1, arvalid_m0};
    eg = (m_ph == 0) ? 2'b00 : (m_own == 1 ? 2'b10 : 2'b01);
    ef = (m_ph == 1) && arv[m_own] && arready_s;
    vecs++;
    if (grant !== eg || ar_en !== (m_ph == 1) || busy !== (m_ph != 0) || ar_fire !== ef ||
        beat_cnt !== CW'(m_beats) || timeout !== m_to) begin
      miss++;
      $display("FAIL model t=%0t got g=%b en=%b busy=%b fire=%b beats=%0d to=%b want g=%b en=%b busy=%b fire=%b beats=%0d to=%b",
               $time, grant, ar_en, busy, ar_fire, beat_cnt, timeout,
               eg, m_ph == 1, m_ph != 0, ef, m_beats, m_to);
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic set(input logic a0, a1, ar, rv, rr, rl);
    arvalid_m0 = a0; arvalid_m1 = a1; arready_s = ar; rvalid_s = rv; rready_m = rr; rlast_s = rl;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    set(1, 0, 0, 0, 0, 0); tick();
    chk("m0_grant", grant, 1);
    chk("addr_ar_en", ar_en, 1);
    set(1, 0, 1, 0, 0, 0); #1 chk("ar_fire", ar_fire, 1); tick();
    chk("data_ar_en", ar_en, 0);
    chk("data_grant", grant, 1);
    set(0, 0, 0, 1, 1, 0); tick(); tick(); tick();
    chk("beats3", beat_cnt, 3);
    set(0, 0, 0, 1, 1, 1); tick();
    chk("beats4", beat_cnt, 4);
    chk("end_busy", busy, 0);
    chk("end_grant", grant, 0);
    set(1, 1, 0, 0, 0, 0); tick();
    chk("rr_to_m1", grant, 2);
    set(1, 0, 1, 0, 0, 0); #1 chk("abort_no_fire", ar_fire, 0); tick();
    chk("abort_idle", busy, 0);
    set(1, 1, 0, 0, 0, 0); tick();
    chk("abort_ptr_kept", grant, 2);
    set(0, 1, 1, 0, 0, 0); tick();
    set(0, 0, 0, 0, 0, 0); repeat (7) tick();
    chk("to_not_yet", timeout, 0);
    tick();
    chk("to_pulse", timeout, 1);
    chk("to_idle", busy, 0);
    tick();
    chk("to_single", timeout, 0);
    set(1, 1, 0, 0, 0, 0); tick();
    chk("to_ptr_flip", grant, 1);
    set(1, 0, 1, 0, 0, 0); tick();
    set(0, 0, 0, 0, 0, 0); repeat (7) tick();
    set(0, 0, 0, 1, 1, 0); tick();
    chk("beat_wins_to", timeout, 0);
    chk("beat_wins_cnt", beat_cnt, 1);
    set(0, 0, 0, 0, 0, 0); repeat (7) tick();
    chk("wd_cleared", busy, 1);
    tick();
    chk("wd_restart_to", timeout, 1);
    set(1, 0, 0, 0, 0, 0); tick();
    set(1, 0, 1, 0, 0, 0); tick();
    set(0, 0, 0, 1, 1, 0); repeat (9) tick();
    chk("beat_sat", beat_cnt, BMAX);
    set(0, 0, 0, 1, 1, 1); tick();
    set(1, 1, 0, 0, 0, 0); tick();
    chk("pre_rst_m1", grant, 2);
    set(1, 1, 1, 0, 0, 0); tick();
    set(0, 0, 0, 1, 1, 0); tick();
    #2 rst = 1;
    #1 chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_beats", beat_cnt, 0);
    chk("arst_ar_en", ar_en, 0);
    set(1, 1, 0, 0, 0, 0); tick();
    #1 rst = 0;
    tick();
    chk("post_rst_m0", grant, 1);
    for (int i = 0; i < 3000; i++) begin
      set($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 4) < 3,
          $urandom_range(0, 4) < 2, $urandom_range(0, 4) < 4, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1;
        #1 rst = 0;
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
